ss_scan_driver: RTL and testbench

//  - Parametrised multiplexed seven-segment scan driver: NUM_DIGITS hex digits with per-digit decimal point and enable.
//  - Adds global PWM brightness, anti-ghosting dead time between digit slots, and frame-synchronous double-buffered loading.
//  - Sits between the display data source and the board's active-low anode/segment pins.

---
 rtl/ss_pkg.sv | 25 ++
 rtl/ss_hex_decoder.sv | 32 +++
 rtl/ss_scan_driver.sv | 151 +++++++++++++++
 tb/tb_ss_scan_driver.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan driver.
// Active-high 7-bit segment patterns {g,f,e,d,c,b,a} for hex 0-F, plus dark codes.
package ss_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [6:0] SEG_OFF   = 7'h00;
    localparam logic [7:0] DARK_BYTE = 8'hFF;

endpackage

// File: rtl/ss_hex_decoder.sv
// Combinational hex digit to active-high segment decoder.
// Ports: value (4-bit digit) -> segments ({g,f,e,d,c,b,a}, 1 = lit).
module ss_hex_decoder
    import ss_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_OFF;
        unique case (value)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
        endcase
    end

endmodule

// File: rtl/ss_scan_driver.sv
// Multiplexed seven-segment scan driver with PWM dimming, dead time and
// frame-synchronous double buffering. Optional macro: SS_ZERO_BLANK_EN
// (leading-zero suppression on the active buffer).
// Ports: Clk, Reset (sync, active-high); BCD/DP/DigitEnable/Brightness/Load
// data inputs; SegmentDrivers (anodes, active low), SevenSegment
// ({dp,g,f,e,d,c,b,a}, active low), FrameDone (pulse after scan wraps).
module ss_scan_driver
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int PRESCALE_BITS = 17,
    parameter int BLANK_CYCLES  = 64,
    parameter int PWM_BITS      = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] BCD,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [NUM_DIGITS-1:0]   DigitEnable,
    input  logic [PWM_BITS-1:0]     Brightness,
    input  logic                    Load,
    output logic [NUM_DIGITS-1:0]   SegmentDrivers,
    output logic [7:0]              SevenSegment,
    output logic                    FrameDone
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESCALE_BITS-1:0] BLANK_END =
        PRESCALE_BITS'(BLANK_CYCLES);

    logic [PRESCALE_BITS-1:0] prescaler;
    logic [IDX_W-1:0]         digit_idx;
    logic [PWM_BITS-1:0]      pwm_cnt;

    logic [4*NUM_DIGITS-1:0]  pend_bcd, act_bcd;
    logic [NUM_DIGITS-1:0]    pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]    pend_en, act_en;
    logic [PWM_BITS-1:0]      pend_br, act_br;
    logic                     pend_valid;

    logic                     slot_end;
    logic                     wrap;
    logic                     in_dead;
    logic                     pwm_on;
    logic                     lit;
    logic [NUM_DIGITS-1:0]    blank_mask;
    logic [3:0]               cur_value;
    logic [6:0]               cur_seg;
    logic [NUM_DIGITS-1:0]    anode_next;
    logic [7:0]               seg_next;

    assign slot_end = &prescaler;
    assign wrap     = slot_end && (digit_idx == LAST_IDX);
    assign in_dead  = prescaler < BLANK_END;
    assign pwm_on   = pwm_cnt < act_br;

`ifdef SS_ZERO_BLANK_EN
    logic suppress;

    // Walk from the most significant digit down; disabled digits neither
    // show nor end the run of leading zeros. Digit 0 is always shown.
    always_comb begin
        blank_mask = '0;
        suppress   = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (act_en[i]) begin
                if (suppress && act_bcd[4*i +: 4] == 4'h0 && !act_dp[i]) begin
                    blank_mask[i] = 1'b1;
                end else begin
                    suppress = 1'b0;
                end
            end
        end
    end
`else
    assign blank_mask = '0;
`endif

    assign cur_value = act_bcd[4*int'(digit_idx) +: 4];

    ss_hex_decoder u_dec (
        .value    (cur_value),
        .segments (cur_seg)
    );

    always_comb begin
        lit        = !in_dead && act_en[digit_idx] && !blank_mask[digit_idx];
        anode_next = '1;
        seg_next   = DARK_BYTE;
        if (lit) begin
            anode_next = ~(NUM_DIGITS'(1) << digit_idx);
            if (pwm_on) begin
                seg_next = {~act_dp[digit_idx], ~cur_seg};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prescaler      <= '0;
            digit_idx      <= '0;
            pwm_cnt        <= '0;
            pend_bcd       <= '0;
            pend_dp        <= '0;
            pend_en        <= '0;
            pend_br        <= '0;
            pend_valid     <= 1'b0;
            act_bcd        <= '0;
            act_dp         <= '0;
            act_en         <= '0;
            act_br         <= '0;
            SegmentDrivers <= '1;
            SevenSegment   <= DARK_BYTE;
            FrameDone      <= 1'b0;
        end else begin
            prescaler <= prescaler + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            if (slot_end) begin
                digit_idx <= wrap ? '0 : digit_idx + 1'b1;
            end

            // A Load on the wrap cycle bypasses the pending buffer.
            if (wrap) begin
                if (Load) begin
                    act_bcd <= BCD;
                    act_dp  <= DP;
                    act_en  <= DigitEnable;
                    act_br  <= Brightness;
                end else if (pend_valid) begin
                    act_bcd <= pend_bcd;
                    act_dp  <= pend_dp;
                    act_en  <= pend_en;
                    act_br  <= pend_br;
                end
                pend_valid <= 1'b0;
            end else if (Load) begin
                pend_bcd   <= BCD;
                pend_dp    <= DP;
                pend_en    <= DigitEnable;
                pend_br    <= Brightness;
                pend_valid <= 1'b1;
            end

            SegmentDrivers <= anode_next;
            SevenSegment   <= seg_next;
            FrameDone      <= wrap;
        end
    end

endmodule

// File: tb/tb_ss_scan_driver.sv
// Self-checking bench for ss_scan_driver (4 digits, 16-cycle slots).
// Table vectors, hand sequences and a cycle-level reference model.
module tb_ss_scan_driver;

    localparam int ND   = 4;
    localparam int PSB  = 4;
    localparam int BLK  = 2;
    localparam int PWB  = 4;
    localparam int SLOT = 1 << PSB;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [4*ND-1:0] BCD;
    logic [ND-1:0]   DP;
    logic [ND-1:0]   DigitEnable;
    logic [PWB-1:0]  Brightness;
    logic            Load;
    logic [ND-1:0]   SegmentDrivers;
    logic [7:0]      SevenSegment;
    logic            FrameDone;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ss_scan_driver #(
        .NUM_DIGITS    (ND),
        .PRESCALE_BITS (PSB),
        .BLANK_CYCLES  (BLK),
        .PWM_BITS      (PWB)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .BCD            (BCD),
        .DP             (DP),
        .DigitEnable    (DigitEnable),
        .Brightness     (Brightness),
        .Load           (Load),
        .SegmentDrivers (SegmentDrivers),
        .SevenSegment   (SevenSegment),
        .FrameDone      (FrameDone)
    );

    // Active-high {g,f,e,d,c,b,a} glyphs for hex 0-F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Digit d is a suppressed leading zero when it and every enabled
    // digit above it hold 0 with no decimal point.
    function automatic logic zero_blanked(input int d,
                                          input logic [4*ND-1:0] b,
                                          input logic [ND-1:0] dp,
                                          input logic [ND-1:0] en);
`ifdef SS_ZERO_BLANK_EN
        if (d == 0 || !en[d]) return 1'b0;
        for (int j = d; j < ND; j++) begin
            if (en[j] && (b[4*j +: 4] != 4'h0 || dp[j])) return 1'b0;
        end
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: position in the scan derived from the cycle count.
    int              m_cyc;
    logic [4*ND-1:0] m_abcd, m_pbcd;
    logic [ND-1:0]   m_adp, m_aen, m_pdp, m_pen;
    logic [PWB-1:0]  m_abr, m_pbr;
    logic            m_pv;
    logic [ND-1:0]   e_an;
    logic [7:0]      e_seg;
    logic            e_fd;

    always @(posedge Clk) begin : model
        int   ph, sl, pw;
        logic on, wr;
        if (Reset) begin
            m_cyc  <= 0;
            m_abcd <= '0; m_adp <= '0; m_aen <= '0; m_abr <= '0;
            m_pbcd <= '0; m_pdp <= '0; m_pen <= '0; m_pbr <= '0;
            m_pv   <= 1'b0;
            e_an   <= '1;
            e_seg  <= 8'hFF;
            e_fd   <= 1'b0;
        end else begin
            ph = m_cyc % SLOT;
            sl = (m_cyc / SLOT) % ND;
            pw = m_cyc % (1 << PWB);
            on = (ph >= BLK) && m_aen[sl] &&
                 !zero_blanked(sl, m_abcd, m_adp, m_aen);
            wr = (ph == SLOT - 1) && (sl == ND - 1);
            e_an  <= on ? ~(ND'(1) << sl) : '1;
            e_seg <= (on && pw < int'(m_abr)) ?
                     {~m_adp[sl], ~GLYPH[m_abcd[4*sl +: 4]]} : 8'hFF;
            e_fd  <= wr;
            if (wr) begin
                if (Load) begin
                    m_abcd <= BCD; m_adp <= DP;
                    m_aen  <= DigitEnable; m_abr <= Brightness;
                end else if (m_pv) begin
                    m_abcd <= m_pbcd; m_adp <= m_pdp;
                    m_aen  <= m_pen;  m_abr <= m_pbr;
                end
                m_pv <= 1'b0;
            end else if (Load) begin
                m_pbcd <= BCD; m_pdp <= DP;
                m_pen  <= DigitEnable; m_pbr <= Brightness;
                m_pv   <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    int shown = 0;

    task automatic report(input string name, input int act, input int req);
        errors++;
        if (shown < 40) begin
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, req, $time);
            shown++;
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(negedge Clk);
        checks++;
        if (SegmentDrivers !== e_an)
            report("model_anode", int'(SegmentDrivers), int'(e_an));
        checks++;
        if (SevenSegment !== e_seg)
            report("model_seg", int'(SevenSegment), int'(e_seg));
        checks++;
        if (FrameDone !== e_fd)
            report("model_framedone", int'(FrameDone), int'(e_fd));
        checks++;
        if ($countones(~SegmentDrivers) > 1)
            report("one_anode", int'(SegmentDrivers), 'hF);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (FrameDone !== 1'b1 && n < 4 * ND * SLOT) begin
            tick();
            n++;
        end
        if (FrameDone !== 1'b1) report("frame_timeout", n, 0);
    endtask

    task automatic expect_out(input string name,
                              input logic [ND-1:0] an,
                              input logic [7:0] seg);
        checks++;
        if (SegmentDrivers !== an)
            report({name, "_anode"}, int'(SegmentDrivers), int'(an));
        checks++;
        if (SevenSegment !== seg)
            report({name, "_seg"}, int'(SevenSegment), int'(seg));
    endtask

    task automatic load(input logic [4*ND-1:0] b, input logic [ND-1:0] dp,
                        input logic [ND-1:0] en, input logic [PWB-1:0] br);
        BCD = b; DP = dp; DigitEnable = en; Brightness = br;
        Load = 1'b1;
        tick();
        Load = 1'b0;
    endtask

    typedef struct {
        string           name;
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   en;
        logic [PWB-1:0]  br;
        int              slot;
        int              phase;
        logic [ND-1:0]   an;
        logic [7:0]      seg;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int n;
        vecs[0]  = '{"d1_three_dp", 16'h1234, 4'b0010, 4'hF, 4'd15, 1, 5,
                     4'b1101, 8'h30};
        vecs[1]  = '{"d0_four", 16'h1234, 4'b0010, 4'hF, 4'd15, 0, 5,
                     4'b1110, 8'h99};
        vecs[2]  = '{"d2_two", 16'h1234, 4'b0010, 4'hF, 4'd15, 2, 9,
                     4'b1011, 8'hA4};
        vecs[3]  = '{"d3_one", 16'h1234, 4'b0010, 4'hF, 4'd15, 3, 14,
                     4'b0111, 8'hF9};
        vecs[4]  = '{"dead_time", 16'h1234, 4'b0010, 4'hF, 4'd15, 1, 1,
                     4'hF, 8'hFF};
`ifdef SS_ZERO_BLANK_EN
        vecs[5]  = '{"lead_zero", 16'h0070, 4'b0000, 4'hF, 4'd15, 3, 5,
                     4'hF, 8'hFF};
`else
        vecs[5]  = '{"lead_zero", 16'h0070, 4'b0000, 4'hF, 4'd15, 3, 5,
                     4'b0111, 8'hC0};
`endif
        vecs[6]  = '{"inner_seven", 16'h0070, 4'b0000, 4'hF, 4'd15, 1, 5,
                     4'b1101, 8'hF8};
        vecs[7]  = '{"last_zero", 16'h0070, 4'b0000, 4'hF, 4'd15, 0, 5,
                     4'b1110, 8'hC0};
        vecs[8]  = '{"disabled", 16'h1234, 4'b0000, 4'b1011, 4'd15, 2, 5,
                     4'hF, 8'hFF};
        vecs[9]  = '{"bright_zero", 16'h1234, 4'b0000, 4'hF, 4'd0, 0, 5,
                     4'b1110, 8'hFF};
        vecs[10] = '{"pwm_on_phase", 16'h0070, 4'b0000, 4'hF, 4'd4, 1, 3,
                     4'b1101, 8'hF8};
        vecs[11] = '{"pwm_off_phase", 16'h0070, 4'b0000, 4'hF, 4'd4, 1, 4,
                     4'b1101, 8'hFF};
        vecs[12] = '{"hex_a", 16'hABCD, 4'b0000, 4'hF, 4'd15, 3, 7,
                     4'b0111, 8'h88};

        Reset = 1'b1; Load = 1'b0;
        BCD = '0; DP = '0; DigitEnable = '0; Brightness = '0;
        ticks(3);
        expect_out("reset", 4'hF, 8'hFF);
        Reset = 1'b0;
        ticks(20);
        expect_out("dark_before_load", 4'hF, 8'hFF);

        wait_frame();
        n = 0;
        do begin
            tick();
            n++;
        end while (FrameDone !== 1'b1 && n < 200);
        checks++;
        if (n != ND * SLOT) report("frame_period", n, ND * SLOT);

        ticks(10);
        load(16'h1234, 4'b0010, 4'hF, 4'd15);
        tick();
        expect_out("no_change_midframe", 4'hF, 8'hFF);

        foreach (vecs[k]) begin
            load(vecs[k].bcd, vecs[k].dp, vecs[k].en, vecs[k].br);
            wait_frame();
            ticks(vecs[k].slot * SLOT + vecs[k].phase + 1);
            expect_out(vecs[k].name, vecs[k].an, vecs[k].seg);
        end

        load(16'h5678, 4'b0000, 4'hF, 4'd15);
        load(16'h1234, 4'b0010, 4'hF, 4'd15);
        wait_frame();
        ticks(SLOT + 6);
        expect_out("last_load_wins", 4'b1101, 8'h30);

        ticks(SLOT - 6);
        load(16'h9999, 4'hF, 4'hF, 4'd15);
        Reset = 1'b1;
        tick();
        expect_out("reset_midframe", 4'hF, 8'hFF);
        Reset = 1'b0;
        wait_frame();
        ticks(SLOT + 6);
        expect_out("pending_discarded", 4'hF, 8'hFF);

        for (int i = 0; i < 2500; i++) begin
            BCD         = 16'($urandom);
            DP          = 4'($urandom);
            DigitEnable = 4'($urandom);
            Brightness  = 4'($urandom);
            Load        = ($urandom_range(0, 11) == 0);
            Reset       = ($urandom_range(0, 499) == 0);
            tick();
        end
        Reset = 1'b0;
        Load  = 1'b0;
        ticks(2 * ND * SLOT);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
